simon_sequence_gen: RTL

- Upstream source of the colour sequence for the Simon datapath. It replaces the hand-loaded switch pattern.
- Generates pseudo-random 2-bit colours (B=0, G=1, R=2, Y=3) from a free-running LFSR and stores them in a sequence memory.
- Grows the sequence by one colour per level.
- Plays the stored sequence back one colour per request. Consumers are the show stage (LED display) and the comparator (player check).

---
 rtl/simon_pkg.sv | 31 +++
 rtl/simon_lfsr.sv | 29 ++
 rtl/simon_sequence_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// ---------------------------------------------------------------------------
// simon_pkg
// Shared definitions for the Simon sequence generator:
//   - 2-bit colour codes (blue, green, red, yellow)
//   - LFSR tap mask and reset seed
//   - state encoding of the sequence generator FSM
//   - one-step helper for the Galois LFSR
// ---------------------------------------------------------------------------
package simon_pkg;

  localparam logic [1:0] COL_B = 2'd0;
  localparam logic [1:0] COL_G = 2'd1;
  localparam logic [1:0] COL_R = 2'd2;
  localparam logic [1:0] COL_Y = 2'd3;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } seq_state_t;

  // Right-shifting Galois step: the bit shifted out decides whether the
  // tap mask is folded back into the register.
  function automatic logic [15:0] lfsr_step(input logic [15:0] value);
    return (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// ---------------------------------------------------------------------------
// simon_lfsr
// Free-running 16-bit Galois LFSR used as the colour source.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset, loads SEED
//   out    out  current LFSR value (16 bits)
// ---------------------------------------------------------------------------
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] out
);

  // The register steps every cycle, whatever the sequence FSM is doing, so
  // the colour picked depends on how long the player took between levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= SEED;
    end else begin
      out <= lfsr_step(out);
    end
  end

endmodule

// File: rtl/simon_sequence_gen.sv
// ---------------------------------------------------------------------------
// simon_sequence_gen
// Builds and plays back the Simon colour sequence. Random colours come from
// a free-running LFSR, are stored one per level in a small register array,
// and are replayed one colour per 'next' request.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   new_game     in   strobe: clear the sequence and generate its first colour
//   append       in   strobe: add one random colour (level up)
//   rewind       in   strobe: read pointer back to index 0
//   next         in   strobe: emit colour at read pointer and advance
//   color        out  last emitted colour (held between emits)
//   color_valid  out  one-cycle pulse marking an emit
//   rd_idx       out  read pointer
//   length       out  number of stored colours, 0..MAX_LEN
//   seq_end      out  playback exhausted (read pointer == length)
//   full         out  length == MAX_LEN
//   ready        out  generator accepts append/rewind/next
// ---------------------------------------------------------------------------
module simon_sequence_gen
  import simon_pkg::*;
#(
  parameter int          MAX_LEN = 16,
  parameter int          IDX_W   = 4,
  parameter logic [15:0] SEED    = LFSR_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_game,
  input  logic             append,
  input  logic             rewind,
  input  logic             next,
  output logic [1:0]       color,
  output logic             color_valid,
  output logic [IDX_W-1:0] rd_idx,
  output logic [IDX_W:0]   length,
  output logic             seq_end,
  output logic             full,
  output logic             ready
);

  localparam int LEN_W = IDX_W + 1;

  seq_state_t state, state_next;

  logic [15:0]      lfsr;
  logic             lfsr_unused;
  logic [1:0]       mem [MAX_LEN];
  logic [LEN_W-1:0] rd_ptr;

  logic do_clear;
  logic do_fill;
  logic do_rewind;
  logic do_emit;

  simon_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .out  (lfsr)
  );

  // Only the two low bits pick a colour; the rest just keep the LFSR long.
  assign lfsr_unused = ^lfsr[15:2];

  // The read pointer is kept one bit wider than rd_idx so that a full
  // 16-colour sequence can reach its end (pointer == length == 16) without
  // wrapping back to "not exhausted".
  assign rd_idx  = rd_ptr[IDX_W-1:0];
  assign seq_end = (rd_ptr == length);
  assign full    = (length == LEN_W'(MAX_LEN));
  assign ready   = (state == READY);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and command arbitration. new_game wins everywhere;
  // in READY only the highest-priority strobe present is considered, so an
  // append on a full sequence swallows any rewind/next in the same cycle.
  always_comb begin
    state_next = state;
    do_clear   = 1'b0;
    do_fill    = 1'b0;
    do_rewind  = 1'b0;
    do_emit    = 1'b0;
    if (new_game) begin
      do_clear   = 1'b1;
      state_next = FILL;
    end else begin
      case (state)
        IDLE: begin
          state_next = IDLE;
        end
        FILL: begin
          do_fill    = 1'b1;
          state_next = READY;
        end
        READY: begin
          if (append) begin
            if (!full) begin
              state_next = FILL;
            end
          end else if (rewind) begin
            do_rewind = 1'b1;
          end else if (next && !seq_end) begin
            do_emit = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Length, read pointer and playback output. color_valid defaults low so
  // every emit is a single-cycle pulse; color itself is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      length      <= '0;
      rd_ptr      <= '0;
      color       <= COL_B;
      color_valid <= 1'b0;
    end else begin
      color_valid <= 1'b0;
      if (do_clear) begin
        length <= '0;
        rd_ptr <= '0;
      end else if (do_fill) begin
        length <= length + LEN_W'(1);
        rd_ptr <= '0;
      end else if (do_rewind) begin
        rd_ptr <= '0;
      end else if (do_emit) begin
        color       <= mem[rd_ptr[IDX_W-1:0]];
        color_valid <= 1'b1;
        rd_ptr      <= rd_ptr + LEN_W'(1);
      end
    end
  end

  // Sequence memory write. FILL is only entered with length < MAX_LEN, so
  // the truncated index is always in range. A reset in FILL drops the write.
  always_ff @(posedge clk) begin
    if (!reset && do_fill) begin
      mem[length[IDX_W-1:0]] <= lfsr[1:0];
    end
  end

endmodule
